// File: rtl/vga_fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads always win, pixel writes take idle slots.
// A 3-cycle read pipeline turns de_pre into pix_valid/pix_data; tear-free mode holds writes until vblank.
module vga_fb_port_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 12,
   parameter int FB_DEPTH = 307200,
   parameter int STALL_W  = 16
) (
   input  logic               clk_vga,
   input  logic               rst_n,
   input  logic               de_pre,
   input  logic               frame_start,
   input  logic               vblank,
   input  logic               wr_mode,
   input  logic               w_valid,
   output logic               w_ready,
   input  logic [ADDR_W-1:0]  w_addr,
   input  logic [DATA_W-1:0]  w_data,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               pix_valid,
   output logic [DATA_W-1:0]  pix_data,
   output logic               wr_err,
   output logic [STALL_W-1:0] stall_cnt,
   output logic [1:0]         arb_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      WRITE   = 2'd2,
      WAIT_VB = 2'd3
   } state_t;

   // Compared one bit wider so a depth equal to 2**ADDR_W cannot alias to zero.
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(FB_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ADDR_W-1:0]  ra;
   logic               addr_bad;
   logic               rd_p1;

   always_comb begin
      state_d  = IDLE;
      w_ready  = 1'b0;
      ra       = frame_start ? '0 : rd_addr;
      addr_bad = ({1'b0, w_addr} >= DEPTH_X);
      if (de_pre) begin
         state_d = READ;
      end else if (w_valid && (!wr_mode || vblank)) begin
         state_d = WRITE;
         w_ready = 1'b1;
      end else if (w_valid) begin
         state_d = WAIT_VB;
      end
   end

   assign arb_state = state_q;

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rd_addr   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_p1     <= 1'b0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
         wr_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         // Stage 0: grant -> RAM command
         state_q <= state_d;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         case (state_d)
            READ: begin
               mem_en   <= 1'b1;
               mem_addr <= ra;
               rd_addr  <= (ra == LAST_ADDR) ? '0 : ra + ADDR_W'(1);
            end
            WRITE: begin
               if (addr_bad) begin
                  wr_err <= 1'b1;
               end else begin
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= w_addr;
                  mem_wdata <= w_data;
               end
            end
            default: ;
         endcase
         if (frame_start && state_d != READ) rd_addr <= '0;

         // Stage 1: RAM read in progress
         rd_p1 <= mem_en & ~mem_we;

         // Stage 2: capture returned pixel
         pix_valid <= rd_p1;
         if (rd_p1) pix_data <= mem_rdata;

         if (w_valid && !w_ready && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end

endmodule

// File: tb/tb_vga_fb_port_arbiter.sv
// Directed bench for vga_fb_port_arbiter: a per-cycle vector table plus hand sequences
// for stall/vblank release, read-address wrap, frame_start, stall saturation and async reset.
module tb_vga_fb_port_arbiter;

   localparam int AW    = 19;
   localparam int DW    = 12;
   localparam int DEPTH = 300;
   localparam int SW    = 6;

   logic          clk_vga = 1'b0;
   logic          rst_n = 1'b0;
   logic          de_pre = 1'b0, frame_start = 1'b0, vblank = 1'b0, wr_mode = 1'b0, w_valid = 1'b0;
   logic          w_ready;
   logic [AW-1:0] w_addr = '0;
   logic [DW-1:0] w_data = '0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          wr_err;
   logic [SW-1:0] stall_cnt;
   logic [1:0]    arb_state;

   int checks = 0;
   int errors = 0;

   vga_fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH), .STALL_W(SW)) dut (
      .clk_vga(clk_vga), .rst_n(rst_n), .de_pre(de_pre), .frame_start(frame_start),
      .vblank(vblank), .wr_mode(wr_mode), .w_valid(w_valid), .w_ready(w_ready),
      .w_addr(w_addr), .w_data(w_data), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pix_valid(pix_valid), .pix_data(pix_data), .wr_err(wr_err),
      .stall_cnt(stall_cnt), .arb_state(arb_state)
   );

   always #5 clk_vga = ~clk_vga;

   // RAM model: read data equals the (truncated) address, one cycle after the command.
   always @(posedge clk_vga) begin
      if (mem_en && !mem_we) mem_rdata <= mem_addr[DW-1:0];
   end

   typedef struct {
      logic dp, fs, vb, wm, wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic rdy, en, we;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic pv;
      logic [DW-1:0] pd;
      logic [1:0] st;
      logic [SW-1:0] stl;
      logic err;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic dp, fs, vb, wm, wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic rdy, en, we,
                               input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                               input logic pv, input logic [DW-1:0] pd, input logic [1:0] st,
                               input logic [SW-1:0] stl, input logic err);
      vec_t r;
      r.dp = dp; r.fs = fs; r.vb = vb; r.wm = wm; r.wv = wv; r.wa = wa; r.wd = wd;
      r.rdy = rdy; r.en = en; r.we = we; r.ea = ea; r.ewd = ewd;
      r.pv = pv; r.pd = pd; r.st = st; r.stl = stl; r.err = err;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic set_in(input logic dp, fs, vb, wm, wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      @(negedge clk_vga);
      de_pre = dp; frame_start = fs; vblank = vb; wr_mode = wm; w_valid = wv;
      w_addr = wa; w_data = wd;
   endtask

   task automatic tick();
      @(posedge clk_vga);
      #1;
   endtask

   int exp_stall;

   initial begin
      //            dp fs vb wm wv  wa     wd       rdy en we ea    ewd      pv pd      st stl err
      tbl[0]  = mk(1, 0, 0, 0, 1, 5,     12'h111, 0, 1, 0, 0,    12'h000, 0, 12'h000, 1, 1, 0);
      tbl[1]  = mk(1, 0, 0, 0, 1, 5,     12'h111, 0, 1, 0, 1,    12'h000, 0, 12'h000, 1, 2, 0);
      tbl[2]  = mk(1, 0, 0, 0, 1, 5,     12'h111, 0, 1, 0, 2,    12'h000, 1, 12'h000, 1, 3, 0);
      tbl[3]  = mk(1, 0, 0, 0, 1, 5,     12'h111, 0, 1, 0, 3,    12'h000, 1, 12'h001, 1, 4, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 3,    12'h000, 1, 12'h002, 0, 4, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 3,    12'h000, 1, 12'h003, 0, 4, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 3,    12'h000, 0, 12'h003, 0, 4, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 100,   12'hABC, 1, 1, 1, 100,  12'hABC, 0, 12'h003, 2, 4, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 100,  12'hABC, 0, 12'h003, 0, 4, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1, DEPTH, 12'h555, 1, 0, 0, 100,  12'hABC, 0, 12'h003, 2, 4, 1);
      tbl[10] = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 100,  12'hABC, 0, 12'h003, 0, 4, 1);
      tbl[11] = mk(0, 0, 1, 1, 1, 7,     12'h0F0, 1, 1, 1, 7,    12'h0F0, 0, 12'h003, 2, 4, 1);
      tbl[12] = mk(0, 0, 0, 1, 1, 7,     12'h0F0, 0, 0, 0, 7,    12'h0F0, 0, 12'h003, 3, 5, 1);
      tbl[13] = mk(1, 0, 0, 1, 1, 7,     12'h0F0, 0, 1, 0, 4,    12'h0F0, 0, 12'h003, 1, 6, 1);
      tbl[14] = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 4,    12'h0F0, 0, 12'h003, 0, 6, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 4,    12'h0F0, 1, 12'h004, 0, 6, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0,     12'h000, 0, 0, 0, 4,    12'h0F0, 0, 12'h004, 0, 6, 1);

      // Reset state
      #1;
      chk("rst w_ready", w_ready, 0);
      chk("rst mem_en", mem_en, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst pix_valid", pix_valid, 0);
      chk("rst pix_data", pix_data, 0);
      chk("rst wr_err", wr_err, 0);
      chk("rst stall_cnt", stall_cnt, 0);
      chk("rst arb_state", arb_state, 0);
      repeat (2) @(posedge clk_vga);
      @(negedge clk_vga);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         set_in(tbl[i].dp, tbl[i].fs, tbl[i].vb, tbl[i].wm, tbl[i].wv, tbl[i].wa, tbl[i].wd);
         #1;
         chk($sformatf("v%0d w_ready", i), w_ready, tbl[i].rdy);
         tick();
         chk($sformatf("v%0d mem_en", i), mem_en, tbl[i].en);
         chk($sformatf("v%0d mem_we", i), mem_we, tbl[i].we);
         chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].ea);
         chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].ewd);
         chk($sformatf("v%0d pix_valid", i), pix_valid, tbl[i].pv);
         chk($sformatf("v%0d pix_data", i), pix_data, tbl[i].pd);
         chk($sformatf("v%0d arb_state", i), arb_state, tbl[i].st);
         chk($sformatf("v%0d stall_cnt", i), stall_cnt, tbl[i].stl);
         chk($sformatf("v%0d wr_err", i), wr_err, tbl[i].err);
      end

      // Tear-free hold: 10 stalled cycles, released on the first vblank cycle
      exp_stall = 6;
      for (int i = 0; i < 10; i++) begin
         set_in(0, 0, 0, 1, 1, 20, 12'h222);
         #1;
         chk("hold w_ready", w_ready, 0);
         tick();
         exp_stall++;
         chk("hold arb_state", arb_state, 3);
         chk("hold mem_en", mem_en, 0);
      end
      chk("hold stall_cnt", stall_cnt, 16);
      set_in(0, 0, 1, 1, 1, 20, 12'h222);
      #1;
      chk("vb w_ready", w_ready, 1);
      tick();
      chk("vb mem_we", mem_we, 1);
      chk("vb mem_addr", mem_addr, 20);
      chk("vb stall_cnt", stall_cnt, exp_stall);

      // wr_mode drop takes effect on the same cycle's grant
      set_in(0, 0, 0, 1, 1, 21, 12'h333);
      #1;
      chk("mode1 w_ready", w_ready, 0);
      tick();
      exp_stall++;
      set_in(0, 0, 0, 0, 1, 21, 12'h333);
      #1;
      chk("mode0 w_ready", w_ready, 1);
      tick();
      chk("mode0 mem_addr", mem_addr, 21);
      chk("mode0 mem_wdata", mem_wdata, 12'h333);
      chk("mode0 stall_cnt", stall_cnt, exp_stall);

      // frame_start alone clears the read pointer; then a full frame plus wrap
      set_in(0, 1, 1, 0, 0, 0, 12'h000);
      tick();
      chk("fs mem_en", mem_en, 0);
      for (int i = 0; i <= DEPTH + 1; i++) begin
         set_in(1, 0, 0, 0, 0, 0, 12'h000);
         tick();
         chk($sformatf("frame rd%0d mem_addr", i), mem_addr, i % DEPTH);
         if (i >= 2) begin
            chk($sformatf("frame rd%0d pix_valid", i), pix_valid, 1);
            chk($sformatf("frame rd%0d pix_data", i), pix_data, (i - 2) % DEPTH);
         end
      end
      set_in(1, 1, 0, 0, 0, 0, 12'h000);
      tick();
      chk("fs+rd mem_addr", mem_addr, 0);
      set_in(1, 0, 0, 0, 0, 0, 12'h000);
      tick();
      chk("after fs mem_addr", mem_addr, 1);

      // Stall counter saturation
      for (int i = 0; i < 60; i++) begin
         set_in(0, 0, 0, 1, 1, 9, 12'h000);
         tick();
         if (exp_stall < 63) exp_stall++;
         chk($sformatf("sat%0d stall_cnt", i), stall_cnt, exp_stall);
      end

      // Async reset with two reads in flight
      set_in(1, 0, 0, 0, 0, 0, 12'h000);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 12'h000);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst mem_en", mem_en, 0);
      chk("arst mem_addr", mem_addr, 0);
      chk("arst pix_valid", pix_valid, 0);
      chk("arst pix_data", pix_data, 0);
      chk("arst wr_err", wr_err, 0);
      chk("arst stall_cnt", stall_cnt, 0);
      chk("arst arb_state", arb_state, 0);
      set_in(0, 0, 0, 0, 0, 0, 12'h000);
      @(negedge clk_vga);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("post%0d pix_valid", i), pix_valid, 0);
         chk($sformatf("post%0d mem_en", i), mem_en, 0);
      end
      set_in(1, 0, 0, 0, 0, 0, 12'h000);
      tick();
      chk("post rd mem_addr", mem_addr, 0);
      set_in(0, 0, 0, 0, 0, 0, 12'h000);
      tick();
      tick();
      chk("post rd pix_valid", pix_valid, 1);
      chk("post rd pix_data", pix_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
